// File: rtl/rf_pkg.sv
// Shared constants for the register-file write arbiter.
// Provides the default requester count, data width and register-address width,
// plus the fixed requester indices used by the writeback sources.
package rf_pkg;

  localparam int unsigned RF_AW   = 5;
  localparam int unsigned RF_DW   = 32;
  localparam int unsigned RF_NREQ = 3;

  localparam int unsigned REQ_ALU  = 0;
  localparam int unsigned REQ_MEM  = 1;
  localparam int unsigned REQ_LINK = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot grant selector for the register-file write port.
// Build option: RF_WR_RR_EN selects round-robin search starting at 'pointer';
// without it, fixed priority (lowest index wins) and 'pointer' is ignored.
// Ports:
//   req     - request vector, one bit per requester
//   pointer - round-robin start index (used only with RF_WR_RR_EN)
//   hold    - forces all grants to 0
//   gnt     - one-hot grant (all zero when hold or no request)
module rr_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   pointer,
  input  logic            hold,
  output logic [NREQ-1:0] gnt
);

`ifdef RF_WR_RR_EN
  int unsigned idx;
  logic        found;

  // Walk the requesters starting at the pointer, wrapping modulo NREQ.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      idx = (32'(pointer) + off) % NREQ;
      if (!hold && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`else
  logic found;
  logic unused_pointer;

  assign unused_pointer = ^pointer;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!hold && !found && req[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter with pending-write scoreboard.
// Selects one writeback requester per cycle, registers the winning write onto
// the register-file port, and tracks registers claimed by decode until written.
// Build option: RF_WR_RR_EN enables round-robin arbitration (adds a pointer
// register); the default build is fixed priority with no pointer state.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   hold                  - suppress all grants this cycle
//   req_valid/addr/data   - per-requester write requests (packed)
//   req_ready             - combinational one-hot grant
//   claim_valid/addr      - decode marks a register as write-pending
//   rf_we/waddr/wdata     - registered register-file write port
//   busy_mask             - registered pending-write scoreboard
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned NREQ = RF_NREQ,
  parameter int unsigned DW   = RF_DW,
  parameter int unsigned AW   = RF_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]  req_ready,
  input  logic             claim_valid,
  input  logic [AW-1:0]    claim_addr,
  output logic             rf_we,
  output logic [AW-1:0]    rf_waddr,
  output logic [DW-1:0]    rf_wdata,
  output logic [2**AW-1:0] busy_mask
);

  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned NREG = 2**AW;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   ptr_q;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            wr_eff;

  logic            we_q;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [NREG-1:0] busy_q, busy_d;

  // Reset also masks grants so nothing transfers while rst is high.
  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req     (req_valid),
    .pointer (ptr_q),
    .hold    (hold | rst),
    .gnt     (gnt)
  );

  assign req_ready = gnt;

  // Grants only go to valid requesters, so any grant bit is a transfer.
  always_comb begin
    xfer     = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        xfer     = 1'b1;
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

`ifdef RF_WR_RR_EN
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] sel_idx;

  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) sel_idx = PW'(i);
    end
    ptr_d = ptr_q;
    if (xfer) ptr_d = (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  assign ptr_q = '0;
`endif

  // Writes to r0 complete the handshake but never reach the register file.
  assign wr_eff = xfer && (sel_addr != '0);

  always_comb begin
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (wr_eff) begin
      waddr_d = sel_addr;
      wdata_d = sel_data;
    end
    // Clear first so a same-cycle claim of the same register wins.
    busy_d = busy_q;
    if (wr_eff) busy_d[sel_addr] = 1'b0;
    if (claim_valid && (claim_addr != '0)) busy_d[claim_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= '0;
    end else begin
      we_q    <= wr_eff;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  assign rf_we     = we_q;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = wdata_q;
  assign busy_mask = busy_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed self-checking bench for rf_wr_arbiter (default parameters).
// Expectations follow RF_WR_RR_EN when it is defined for the build.
module tb_rf_wr_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;

  logic              clk;
  logic              rst;
  logic              hold;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              claim_valid;
  logic [AW-1:0]     claim_addr;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DW-1:0]     rf_wdata;
  logic [2**AW-1:0]  busy_mask;

  int checks = 0;
  int errors = 0;

  rf_wr_arbiter #(
    .NREQ (NREQ),
    .DW   (DW),
    .AW   (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hold        (hold),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .busy_mask   (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_reqs(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [AW-1:0] a2, input logic [DW-1:0] d0,
                          input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    req_addr = {a2, a1, a0};
    req_data = {d2, d1, d0};
  endtask

  task automatic test_reset;
    checks++; if (req_ready !== 3'b000) begin errors++;
      $display("FAIL reset_ready: got %b expected 000", req_ready); end
    checks++; if (rf_we !== 1'b0) begin errors++;
      $display("FAIL reset_we: got %b expected 0", rf_we); end
    checks++; if (rf_waddr !== 5'd0) begin errors++;
      $display("FAIL reset_waddr: got %0d expected 0", rf_waddr); end
    checks++; if (rf_wdata !== 32'd0) begin errors++;
      $display("FAIL reset_wdata: got %h expected 0", rf_wdata); end
    checks++; if (busy_mask !== 32'd0) begin errors++;
      $display("FAIL reset_busy: got %h expected 0", busy_mask); end
  endtask

  task automatic test_contention;
    logic [2:0]    exp_g [4];
    logic [AW-1:0] exp_a [4];
`ifdef RF_WR_RR_EN
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_a = '{5'd1, 5'd2, 5'd3, 5'd1};
`else
    exp_g = '{3'b001, 3'b001, 3'b001, 3'b001};
    exp_a = '{5'd1, 5'd1, 5'd1, 5'd1};
`endif
    set_reqs(5'd1, 5'd2, 5'd3, 32'hA0, 32'hA1, 32'hA2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_valid = 3'b111;
      #1;
      checks++; if (req_ready !== exp_g[k]) begin errors++;
        $display("FAIL contention_grant[%0d]: got %b expected %b", k, req_ready, exp_g[k]); end
      @(posedge clk); #1;
      checks++; if (rf_we !== 1'b1 || rf_waddr !== exp_a[k]) begin errors++;
        $display("FAIL contention_write[%0d]: got we=%b addr=%0d expected we=1 addr=%0d",
                 k, rf_we, rf_waddr, exp_a[k]); end
    end
    @(negedge clk);
    req_valid = 3'b000;
  endtask

  task automatic test_single;
    set_reqs(5'd5, 5'd0, 5'd0, 32'h1234, 32'h0, 32'h0);
    req_valid = 3'b001;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++;
      $display("FAIL single_ready: got %b expected 001", req_ready); end
    @(posedge clk); #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin errors++;
      $display("FAIL single_write: got we=%b addr=%0d data=%h expected 1/5/1234",
               rf_we, rf_waddr, rf_wdata); end
    @(negedge clk);
    req_valid = 3'b000;
    @(posedge clk); #1;
    checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin errors++;
      $display("FAIL idle_hold: got we=%b addr=%0d data=%h expected 0/5/1234",
               rf_we, rf_waddr, rf_wdata); end
  endtask

  task automatic test_reg0;
    @(negedge clk);
    set_reqs(5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0);
    req_valid = 3'b001;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++;
      $display("FAIL reg0_ready: got %b expected 001", req_ready); end
    @(posedge clk); #1;
    checks++; if (rf_we !== 1'b0) begin errors++;
      $display("FAIL reg0_we: got %b expected 0", rf_we); end
    @(negedge clk);
    req_valid = 3'b000;
  endtask

  task automatic test_scoreboard;
    @(negedge clk);
    claim_valid = 1'b1; claim_addr = 5'd7;
    @(posedge clk); #1;
    checks++; if (busy_mask !== 32'h80) begin errors++;
      $display("FAIL sb_claim: got %h expected 00000080", busy_mask); end
    @(negedge clk);
    claim_valid = 1'b0;
    set_reqs(5'd7, 5'd0, 5'd0, 32'h77, 32'h0, 32'h0);
    req_valid = 3'b001;
    @(posedge clk); #1;
    checks++; if (busy_mask !== 32'h0 || rf_we !== 1'b1 || rf_waddr !== 5'd7) begin errors++;
      $display("FAIL sb_clear: got busy=%h we=%b addr=%0d expected 0/1/7",
               busy_mask, rf_we, rf_waddr); end
    @(negedge clk);
    req_valid = 3'b000;
    claim_valid = 1'b1; claim_addr = 5'd7;
    @(posedge clk);
    @(negedge clk);
    req_valid = 3'b001;
    @(posedge clk); #1;
    checks++; if (busy_mask !== 32'h80) begin errors++;
      $display("FAIL sb_set_wins: got %h expected 00000080", busy_mask); end
    @(negedge clk);
    req_valid = 3'b000;
    claim_addr = 5'd0;
    @(posedge clk); #1;
    checks++; if (busy_mask !== 32'h80) begin errors++;
      $display("FAIL sb_claim0: got %h expected 00000080", busy_mask); end
    @(negedge clk);
    claim_valid = 1'b0;
    set_reqs(5'd9, 5'd0, 5'd0, 32'h99, 32'h0, 32'h0);
    req_valid = 3'b001;
    @(posedge clk); #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h99 ||
                  busy_mask !== 32'h80) begin errors++;
      $display("FAIL sb_unclaimed: got we=%b addr=%0d data=%h busy=%h expected 1/9/99/80",
               rf_we, rf_waddr, rf_wdata, busy_mask); end
    @(negedge clk);
    req_valid = 3'b000;
  endtask

  task automatic test_hold;
    logic [2:0]    exp_g;
    logic [AW-1:0] exp_a;
`ifdef RF_WR_RR_EN
    exp_g = 3'b010; exp_a = 5'd2;
`else
    exp_g = 3'b001; exp_a = 5'd1;
`endif
    @(negedge clk);
    set_reqs(5'd1, 5'd2, 5'd3, 32'hB0, 32'hB1, 32'hB2);
    hold = 1'b1;
    req_valid = 3'b111;
    #1;
    checks++; if (req_ready !== 3'b000) begin errors++;
      $display("FAIL hold_ready: got %b expected 000", req_ready); end
    @(posedge clk); #1;
    checks++; if (rf_we !== 1'b0) begin errors++;
      $display("FAIL hold_we: got %b expected 0", rf_we); end
    @(negedge clk);
    hold = 1'b0;
    #1;
    checks++; if (req_ready !== exp_g) begin errors++;
      $display("FAIL hold_release: got %b expected %b", req_ready, exp_g); end
    @(posedge clk); #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== exp_a) begin errors++;
      $display("FAIL hold_release_write: got we=%b addr=%0d expected 1/%0d",
               rf_we, rf_waddr, exp_a); end
    @(negedge clk);
    req_valid = 3'b000;
  endtask

  task automatic test_priority;
    logic [2:0] exp_g;
`ifdef RF_WR_RR_EN
    exp_g = 3'b100;
`else
    exp_g = 3'b010;
`endif
    @(negedge clk);
    req_valid = 3'b110;
    #1;
    checks++; if (req_ready !== exp_g) begin errors++;
      $display("FAIL priority_110: got %b expected %b", req_ready, exp_g); end
    @(negedge clk);
    req_valid = 3'b000;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    set_reqs(5'd3, 5'd2, 5'd3, 32'h33, 32'hC1, 32'hC2);
    req_valid = 3'b001;
    @(posedge clk); #1;
    checks++; if (rf_we !== 1'b1 || busy_mask !== 32'h80) begin errors++;
      $display("FAIL midrst_pre: got we=%b busy=%h expected 1/80", rf_we, busy_mask); end
    #1;
    rst = 1'b1;
    set_reqs(5'd1, 5'd2, 5'd3, 32'hD0, 32'hD1, 32'hD2);
    req_valid = 3'b111;
    #1;
    checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 ||
                  busy_mask !== 32'd0 || req_ready !== 3'b000) begin errors++;
      $display("FAIL midrst_async: got we=%b addr=%0d data=%h busy=%h rdy=%b expected all 0",
               rf_we, rf_waddr, rf_wdata, busy_mask, req_ready); end
    @(posedge clk); #1;
    checks++; if (req_ready !== 3'b000 || rf_we !== 1'b0) begin errors++;
      $display("FAIL midrst_held: got rdy=%b we=%b expected 000/0", req_ready, rf_we); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++;
      $display("FAIL midrst_first_grant: got %b expected 001", req_ready); end
    @(posedge clk); #1;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'hD0) begin errors++;
      $display("FAIL midrst_first_write: got we=%b addr=%0d data=%h expected 1/1/d0",
               rf_we, rf_waddr, rf_wdata); end
    @(negedge clk);
    req_valid = 3'b000;
  endtask

  initial begin
    rst = 1'b1;
    hold = 1'b0;
    claim_valid = 1'b0;
    claim_addr = '0;
    req_valid = 3'b111;
    set_reqs(5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
    #12;
    test_reset;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 3'b000;
    test_contention;
    test_single;
    test_reg0;
    test_scoreboard;
    test_hold;
    test_priority;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
